// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and requester indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ADDR   = 2'd1,
    ARB_ACCESS = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_e;

  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_DMA = 1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    unique case (req)
      2'b01:   win[REQ_CPU] = 1'b1;
      2'b10:   win[REQ_DMA] = 1'b1;
      2'b11: begin
        if (last == 1'b1) win[REQ_CPU] = 1'b1;
        else              win[REQ_DMA] = 1'b1;
      end
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a CPU and a loader/DMA
// port; each transaction walks IDLE -> ADDR -> ACCESS -> DONE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [DATA_W-1:0]         mem_rdata
);

  arb_state_e          r_state;
  arb_state_e          w_state_next;
  logic [N_REQ-1:0]    r_gnt;
  logic [N_REQ-1:0]    r_done;
  logic                r_we;
  logic                r_last;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;

  logic [1:0]          w_win;
  logic                w_start;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  rr_pick2 u_pick (
    .req  (req[1:0]),
    .last (r_last),
    .win  (w_win)
  );

  // Mux the winning requester's command so it can be latched at the IDLE edge.
  always_comb begin
    w_sel_we    = req_we[REQ_CPU];
    w_sel_addr  = req_addr[REQ_CPU*ADDR_W +: ADDR_W];
    w_sel_wdata = req_wdata[REQ_CPU*DATA_W +: DATA_W];
    if (w_win[REQ_DMA]) begin
      w_sel_we    = req_we[REQ_DMA];
      w_sel_addr  = req_addr[REQ_DMA*ADDR_W +: ADDR_W];
      w_sel_wdata = req_wdata[REQ_DMA*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (|req[1:0]) begin
          w_start      = 1'b1;
          w_state_next = ARB_ADDR;
        end
      end
      ARB_ADDR:   w_state_next = ARB_ACCESS;
      ARB_ACCESS: begin
        mem_we       = r_we;
        mem_re       = ~r_we;
        w_state_next = ARB_DONE;
      end
      ARB_DONE:   w_state_next = ARB_IDLE;
      default:    w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_we    <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= '0;
      if (w_start) begin
        r_gnt   <= w_win;
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == ARB_ACCESS) begin
        r_done <= r_gnt;
        if (!r_we) r_rdata <= mem_rdata;
      end
      // A CPU win leaves last = 0, so the DMA port takes the next tie.
      if (r_state == ARB_DONE) begin
        r_gnt  <= '0;
        r_last <= r_gnt[REQ_DMA];
      end
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized contention
// against a transaction-level reference model with its own memory image.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, req_we;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  gnt, done;
  logic [7:0]  rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  int checks = 0;
  int errors = 0;

  // Environment RAM (written only by the DUT) and the model's memory image.
  logic [7:0] ram      [256];
  logic [7:0] init_val [256];
  logic [7:0] ref_mem  [256];
  logic       ram_init;

  int         m_last;
  logic [7:0] exp_rdata;

  logic [1:0] o_gnt [64];
  logic [1:0] o_done[64];
  logic       o_we  [64];
  logic       o_re  [64];
  logic [7:0] o_addr[64];
  logic [7:0] o_wdata[64];
  logic [7:0] o_rdata[64];

  logic [1:0] prev_gnt;

  mem_arbiter #(.N_REQ(2), .ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val[i];
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  // Grant is one-hot or zero; done only follows a cycle with the matching grant.
  always @(negedge clk) begin
    if (!reset && !$isunknown({gnt, done, prev_gnt})) begin
      checks++;
      if ($countones(gnt) > 1 || (done & ~prev_gnt) != 2'b00) begin
        errors++;
        $display("FAIL gnt_done_rule gnt=%b done=%b prev_gnt=%b", gnt, done, prev_gnt);
      end
    end
    prev_gnt <= gnt;
  end

  task automatic rec(input int k);
    @(posedge clk);
    #1;
    o_gnt[k]   = gnt;
    o_done[k]  = done;
    o_we[k]    = mem_we;
    o_re[k]    = mem_re;
    o_addr[k]  = mem_addr;
    o_wdata[k] = mem_wdata;
    o_rdata[k] = rdata;
  endtask

  task automatic test_reset;
    req = 2'b11; req_we = 2'b11; req_addr = 16'h5AA5; req_wdata = 16'hC33C;
    reset = 1'b1;
    rec(0);
    checks++;
    if ({o_gnt[0], o_done[0], o_we[0], o_re[0], o_rdata[0], o_addr[0], o_wdata[0]} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b done=%b we=%b re=%b rdata=%h addr=%h wdata=%h want all 0",
               o_gnt[0], o_done[0], o_we[0], o_re[0], o_rdata[0], o_addr[0], o_wdata[0]);
    end
    req = 2'b00; req_we = 2'b00;
    reset = 1'b0;
    m_last = 1;
    exp_rdata = 8'h00;
  endtask

  task automatic test_cpu_read;
    req = 2'b01; req_we = 2'b00; req_addr = 16'h0042; req_wdata = 16'h0000;
    rec(0); rec(1); rec(2);
    req = 2'b00;
    rec(3);
    checks++;
    if (o_gnt[0] !== 2'b01) begin
      errors++; $display("FAIL cpu_read_gnt got %b want 01", o_gnt[0]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({o_we[k], o_re[k]} !== {1'b0, k == 1}) begin
        errors++; $display("FAIL cpu_read_strobe cycle %0d got we/re=%b%b want 0%b", k, o_we[k], o_re[k], k == 1);
      end
      checks++;
      if (o_done[k] !== ((k == 2) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL cpu_read_done cycle %0d got %b", k, o_done[k]);
      end
    end
    checks++;
    if (o_addr[1] !== 8'h42) begin
      errors++; $display("FAIL cpu_read_addr got %h want 42", o_addr[1]);
    end
    checks++;
    if (o_rdata[2] !== ref_mem[8'h42]) begin
      errors++; $display("FAIL cpu_read_rdata got %h want %h", o_rdata[2], ref_mem[8'h42]);
    end
    checks++;
    if (o_gnt[3] !== 2'b00) begin
      errors++; $display("FAIL cpu_read_gnt_clear got %b want 00", o_gnt[3]);
    end
    exp_rdata = ref_mem[8'h42];
    m_last = 0;
  endtask

  task automatic test_dma_write;
    int pulses;
    req = 2'b10; req_we = 2'b10; req_addr = 16'h1077; req_wdata = 16'h3C00;
    rec(0); rec(1); rec(2);
    req = 2'b00;
    rec(3);
    pulses = 0;
    for (int k = 0; k < 4; k++) pulses += int'(o_we[k]);
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL dma_write_pulses got %0d want 1", pulses);
    end
    checks++;
    if ({o_we[1], o_re[1], o_addr[1], o_wdata[1]} !== {1'b1, 1'b0, 8'h10, 8'h3C}) begin
      errors++; $display("FAIL dma_write_bus got we=%b re=%b addr=%h wdata=%h want 1 0 10 3c",
                         o_we[1], o_re[1], o_addr[1], o_wdata[1]);
    end
    checks++;
    if (o_done[2] !== 2'b10 || o_gnt[0] !== 2'b10) begin
      errors++; $display("FAIL dma_write_handshake got gnt=%b done=%b want 10 10", o_gnt[0], o_done[2]);
    end
    checks++;
    if (o_rdata[2] !== exp_rdata) begin
      errors++; $display("FAIL dma_write_rdata_kept got %h want %h", o_rdata[2], exp_rdata);
    end
    ref_mem[8'h10] = 8'h3C;
    m_last = 1;
    // Readback through the CPU port.
    req = 2'b01; req_we = 2'b00; req_addr = 16'h0010;
    rec(0); rec(1); rec(2);
    req = 2'b00;
    rec(3);
    checks++;
    if (o_done[2] !== 2'b01 || o_rdata[2] !== ref_mem[8'h10]) begin
      errors++; $display("FAIL dma_write_readback got done=%b rdata=%h want 01 %h",
                         o_done[2], o_rdata[2], ref_mem[8'h10]);
    end
    exp_rdata = ref_mem[8'h10];
    m_last = 0;
  endtask

  task automatic test_dma_drop;
    int dones;
    logic [7:0] rd;
    req = 2'b10; req_we = 2'b00; req_addr = 16'hA011;
    rec(0);
    req = 2'b00;
    for (int k = 1; k < 6; k++) rec(k);
    dones = 0;
    rd = 8'h00;
    for (int k = 0; k < 6; k++) begin
      dones += int'(o_done[k][1]);
      if (o_done[k][1]) rd = o_rdata[k];
    end
    checks++;
    if (o_gnt[0] !== 2'b10 || dones != 1) begin
      errors++; $display("FAIL dma_drop got gnt=%b dones=%0d want 10 1", o_gnt[0], dones);
    end
    checks++;
    if (rd !== ref_mem[8'hA0]) begin
      errors++; $display("FAIL dma_drop_rdata got %h want %h", rd, ref_mem[8'hA0]);
    end
    exp_rdata = ref_mem[8'hA0];
    m_last = 1;
  endtask

  task automatic test_reset_mid;
    req = 2'b01; req_we = 2'b00; req_addr = 16'hC805;
    rec(0); rec(1); rec(2);
    req = 2'b00;
    rec(3);
    m_last = 0;
    req = 2'b01;
    rec(0); rec(1);
    reset = 1'b1;
    req = 2'b11;
    rec(2);
    checks++;
    if ({o_gnt[2], o_done[2], o_we[2], o_re[2], o_rdata[2], o_addr[2], o_wdata[2]} !== 30'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got gnt=%b done=%b we=%b re=%b rdata=%h addr=%h wdata=%h want all 0",
               o_gnt[2], o_done[2], o_we[2], o_re[2], o_rdata[2], o_addr[2], o_wdata[2]);
    end
    reset = 1'b0;
    m_last = 1;
    rec(3);
    req = 2'b00;
    rec(4); rec(5); rec(6);
    checks++;
    if (o_gnt[3] !== 2'b01) begin
      errors++; $display("FAIL reset_mid_first_winner got %b want 01", o_gnt[3]);
    end
    checks++;
    if (o_done[5] !== 2'b01 || o_rdata[5] !== ref_mem[8'h05]) begin
      errors++; $display("FAIL reset_mid_after got done=%b rdata=%h want 01 %h",
                         o_done[5], o_rdata[5], ref_mem[8'h05]);
    end
    exp_rdata = ref_mem[8'h05];
    m_last = 0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    d = 8'($urandom);
    req = 2'b01; req_we = 2'b01; req_addr = 16'h00FF; req_wdata = {8'h00, d};
    rec(0);
    req_we = 2'b00;
    for (int k = 1; k < 7; k++) rec(k);
    req = 2'b00;
    rec(7);
    checks++;
    if ({o_we[1], o_addr[1], o_wdata[1]} !== {1'b1, 8'hFF, d}) begin
      errors++; $display("FAIL b2b_write got we=%b addr=%h wdata=%h want 1 ff %h",
                         o_we[1], o_addr[1], o_wdata[1], d);
    end
    checks++;
    if (o_rdata[2] !== exp_rdata) begin
      errors++; $display("FAIL b2b_write_rdata_kept got %h want %h", o_rdata[2], exp_rdata);
    end
    checks++;
    if (o_gnt[3] !== 2'b00 || o_gnt[4] !== 2'b01) begin
      errors++; $display("FAIL b2b_regrant got idle=%b next=%b want 00 01", o_gnt[3], o_gnt[4]);
    end
    checks++;
    if ({o_re[5], o_addr[5], o_done[6], o_rdata[6]} !== {1'b1, 8'hFF, 2'b01, d}) begin
      errors++; $display("FAIL b2b_read got re=%b addr=%h done=%b rdata=%h want 1 ff 01 %h",
                         o_re[5], o_addr[5], o_done[6], o_rdata[6], d);
    end
    ref_mem[8'hFF] = d;
    exp_rdata = d;
    m_last = 0;
  endtask

  // Both ports contend at every IDLE; req wanders freely in between.
  task automatic test_random_contention;
    int         w;
    logic       ewe;
    logic [7:0] eaddr, ewdata, erd;
    for (int j = 0; j < 12; j++) begin
      w = 0; ewe = 1'b0; eaddr = 8'h00; ewdata = 8'h00;
      for (int p = 0; p < 4; p++) begin
        req       = (p == 0) ? 2'b11 : 2'($urandom);
        req_we    = 2'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        if (p == 0) begin
          w      = (m_last == 0) ? 1 : 0;
          ewe    = req_we[w];
          eaddr  = req_addr[w*8 +: 8];
          ewdata = req_wdata[w*8 +: 8];
        end
        rec(4*j + p);
      end
      erd = ewe ? exp_rdata : ref_mem[eaddr];
      checks++;
      if (o_gnt[4*j] !== 2'(1 << w)) begin
        errors++; $display("FAIL rand_gnt txn %0d got %b want %b", j, o_gnt[4*j], 2'(1 << w));
      end
      checks++;
      if ({o_we[4*j+1], o_re[4*j+1], o_addr[4*j+1]} !== {ewe, ~ewe, eaddr}) begin
        errors++; $display("FAIL rand_access txn %0d got we=%b re=%b addr=%h want %b %b %h",
                           j, o_we[4*j+1], o_re[4*j+1], o_addr[4*j+1], ewe, ~ewe, eaddr);
      end
      if (ewe) begin
        checks++;
        if (o_wdata[4*j+1] !== ewdata) begin
          errors++; $display("FAIL rand_wdata txn %0d got %h want %h", j, o_wdata[4*j+1], ewdata);
        end
      end
      checks++;
      if ({o_done[4*j], o_done[4*j+1], o_done[4*j+2], o_done[4*j+3]} !== {4'b0000, 2'(1 << w), 2'b00}) begin
        errors++; $display("FAIL rand_done txn %0d got %b %b %b %b", j,
                           o_done[4*j], o_done[4*j+1], o_done[4*j+2], o_done[4*j+3]);
      end
      checks++;
      if (o_rdata[4*j+2] !== erd) begin
        errors++; $display("FAIL rand_rdata txn %0d got %h want %h", j, o_rdata[4*j+2], erd);
      end
      if (ewe) ref_mem[eaddr] = ewdata;
      exp_rdata = erd;
      m_last = w;
    end
    req = 2'b00;
  endtask

  initial begin
    reset = 1'b1; ram_init = 1'b1;
    req = 2'b00; req_we = 2'b00; req_addr = 16'h0000; req_wdata = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      init_val[i] = 8'($urandom);
      ref_mem[i]  = init_val[i];
    end
    init_val[8'h42] = 8'hA5;
    ref_mem[8'h42]  = 8'hA5;
    @(posedge clk);
    #1;
    ram_init = 1'b0;
    test_reset;
    test_cpu_read;
    test_dma_write;
    test_dma_drop;
    test_reset_mid;
    test_back_to_back;
    test_random_contention;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
